gb_frame_capture: RTL and testbench

- Downstream of the gameboy core's LCD output (pixel_data/pixel_clock/pixel_latch/hsync/vsync).
- Converts the serial 2-bpp pixel stream into packed bytes.
- Writes those bytes into a double-buffered framebuffer RAM (160x144, 4 pixels/byte).
- A later display/HDMI scanout reads the completed bank indicated by rd_bank.

---
 rtl/gb_video_pkg.sv | 28 ++
 rtl/gb_sync_edge.sv | 38 +++
 rtl/gb_frame_capture.sv | 195 +++++++++++++++++++
 tb/tb_gb_frame_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared constants, capture state encoding and the pixel packing helper for the Game Boy video path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_video_pkg;

    localparam int GB_WIDTH          = 160;
    localparam int GB_HEIGHT         = 144;
    localparam int GB_BYTES_PER_LINE = 40;
    localparam int GB_BANK_BYTES     = 5760;

    // Pixel packing order: pixel n of a 4-pixel group occupies bits [7-2n:6-2n],
    // so the first pixel on the wire ends up in the byte MSBs.
    localparam int GB_PIX_BITS = 2;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } cap_state_t;

    // Left-justify a partial group. The pack register keeps the newest pixel in
    // its LSBs, so shifting by the missing pixel count leaves zero padding below.
    function automatic logic [7:0] pack_flush(input logic [5:0] pack, input logic [1:0] count);
        logic [7:0] b;
        b = {2'b00, pack} << (GB_PIX_BITS * (4 - int'(count)));
        return b;
    endfunction

endpackage

// File: rtl/gb_sync_edge.sv
// Multi-flop synchronizer for one LCD input; optionally converts it to a registered rising-edge pulse.
// Latency: STAGES clocks to the synchronized level, +1 clock to q (level or pulse mode alike, so both stay aligned).
// Backpressure: none; input is sampled every clock.
//   clock, reset_n : core clock, active-low reset (async assert)
//   d              : asynchronous input
//   q              : EDGE=1 -> one-cycle pulse per rising edge; EDGE=0 -> delayed synchronized level
module gb_sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [STAGES];
    logic [W-1:0] prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
            prev <= '0;
            q    <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
            prev <= stg[STAGES-1];
            q    <= EDGE ? (stg[STAGES-1] & ~prev) : stg[STAGES-1];
        end
    end

endmodule

// File: rtl/gb_frame_capture.sv
// Captures the Game Boy LCD pixel stream into a double-buffered 2-bpp framebuffer (4 pixels per byte).
// Latency: fb_we fires 2 clocks after the synchronized pixel_clock edge (SYNC_STAGES + 2 from the pin).
// Backpressure: none; the RAM write port must accept every fb_we, and excess pixels/lines are dropped and flagged.
//   clock, reset_n        : core clock, async active-low reset (released synchronously inside)
//   pixel_*/hsync/vsync   : raw LCD signals from the core
//   fb_addr/fb_wdata/fb_we: framebuffer write port, bank offset included in fb_addr
//   rd_bank, frame_done   : last completed bank and its completion pulse
//   err_short_line, err_overflow : sticky diagnostics
module gb_frame_capture
    import gb_video_pkg::*;
#(
    parameter int WIDTH       = GB_WIDTH,
    parameter int HEIGHT      = GB_HEIGHT,
    parameter int BANK_BYTES  = GB_BANK_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  pixel_data,
    input  logic        pixel_clock,
    input  logic        pixel_latch,
    input  logic        hsync,
    input  logic        vsync,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        fb_we,
    output logic        rd_bank,
    output logic        frame_done,
    output logic        err_short_line,
    output logic        err_overflow
);

    localparam logic [7:0]  W8     = 8'(WIDTH);
    localparam logic [7:0]  H8     = 8'(HEIGHT);
    localparam logic [13:0] BANK_A = 14'(BANK_BYTES);
    localparam logic [13:0] LINE_A = 14'(WIDTH / 4);

    // Reset: asserts immediately, releases on a clock edge.
    logic [1:0] rst_ff;
    logic       rst_sync_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_ff <= 2'b00;
        else          rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_sync_n = rst_ff[1];

    logic       pix_e, hs_e, vs_e, latch_e;
    logic [1:0] pix_d;

    gb_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_pclk (
        .clock(clock), .reset_n(rst_sync_n), .d(pixel_clock), .q(pix_e));
    gb_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_hs (
        .clock(clock), .reset_n(rst_sync_n), .d(hsync), .q(hs_e));
    gb_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_vs (
        .clock(clock), .reset_n(rst_sync_n), .d(vsync), .q(vs_e));
    gb_sync_edge #(.W(1), .STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_latch (
        .clock(clock), .reset_n(rst_sync_n), .d(pixel_latch), .q(latch_e));
    // Data is kept as a level, delayed to line up with the pixel_clock pulse.
    gb_sync_edge #(.W(2), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_pdat (
        .clock(clock), .reset_n(rst_sync_n), .d(pixel_data), .q(pix_d));

    cap_state_t  state, state_nxt;
    logic        wr_bank, wr_bank_nxt;
    logic [7:0]  x, x_nxt, y, y_nxt;
    logic [13:0] addr, addr_nxt, line_base, base_nxt;
    logic [5:0]  pack, pack_nxt;
    logic [1:0]  latch_cnt, lcnt_nxt, lcnt_eff;
    logic [13:0] faddr_nxt;
    logic [7:0]  wdata_nxt;
    logic        we_nxt, rd_nxt, done_nxt, es_nxt, eo_nxt;
    logic        bank_sel, take_pix;

    always_comb begin
        state_nxt   = state;
        wr_bank_nxt = wr_bank;
        x_nxt       = x;
        y_nxt       = y;
        addr_nxt    = addr;
        base_nxt    = line_base;
        pack_nxt    = pack;
        faddr_nxt   = fb_addr;
        wdata_nxt   = fb_wdata;
        we_nxt      = 1'b0;
        rd_nxt      = rd_bank;
        done_nxt    = 1'b0;
        es_nxt      = err_short_line;
        eo_nxt      = err_overflow;
        bank_sel    = wr_bank;
        take_pix    = 1'b0;
        // A latch edge coincident with hsync still belongs to the line being closed.
        lcnt_eff    = (latch_e && latch_cnt != 2'd3) ? latch_cnt + 2'd1 : latch_cnt;
        lcnt_nxt    = (state == ACTIVE) ? lcnt_eff : latch_cnt;

        if (vs_e) begin
            if (state == ACTIVE) begin
                if (x[1:0] != 2'd0) begin
                    we_nxt    = 1'b1;
                    wdata_nxt = pack_flush(pack, x[1:0]);
                    faddr_nxt = addr;
                    es_nxt    = 1'b1;
                end
                // Only a frame with at least one closed line is published.
                if (y != 8'd0) begin
                    done_nxt = 1'b1;
                    rd_nxt   = wr_bank;
                    bank_sel = ~wr_bank;
                end
            end
            state_nxt   = ACTIVE;
            wr_bank_nxt = bank_sel;
            x_nxt       = 8'd0;
            y_nxt       = 8'd0;
            addr_nxt    = bank_sel ? BANK_A : 14'd0;
            base_nxt    = bank_sel ? BANK_A : 14'd0;
            lcnt_nxt    = 2'd0;
            take_pix    = 1'b1;
        end else if (state == ACTIVE) begin
            take_pix = 1'b1;
            if (hs_e) begin
                if (x[1:0] != 2'd0) begin
                    we_nxt    = 1'b1;
                    wdata_nxt = pack_flush(pack, x[1:0]);
                    faddr_nxt = addr;
                    es_nxt    = 1'b1;
                end
                if (x != 8'd0 && x < W8) es_nxt = 1'b1;
                // The hsync that opens the first line closes an empty one; its latch count is meaningless.
                if (x != 8'd0 && lcnt_eff != 2'd1) es_nxt = 1'b1;
                if (y == H8) begin
                    eo_nxt = 1'b1;
                end else if (x != 8'd0) begin
                    y_nxt    = y + 8'd1;
                    base_nxt = line_base + LINE_A;
                    addr_nxt = line_base + LINE_A;
                end
                x_nxt    = 8'd0;
                lcnt_nxt = 2'd0;
            end
        end

        // Pixel is applied after any line/frame advance so it lands on the new position.
        if (pix_e && take_pix) begin
            if (x_nxt < W8 && y_nxt < H8) begin
                pack_nxt = {pack[3:0], pix_d};
                if (x_nxt[1:0] == 2'd3) begin
                    we_nxt    = 1'b1;
                    wdata_nxt = {pack, pix_d};
                    faddr_nxt = addr_nxt;
                    addr_nxt  = addr_nxt + 14'd1;
                end
                x_nxt = x_nxt + 8'd1;
            end else begin
                eo_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state          <= WAIT_FRAME;
            wr_bank        <= 1'b0;
            x              <= 8'd0;
            y              <= 8'd0;
            addr           <= 14'd0;
            line_base      <= 14'd0;
            pack           <= 6'd0;
            latch_cnt      <= 2'd0;
            fb_addr        <= 14'd0;
            fb_wdata       <= 8'd0;
            fb_we          <= 1'b0;
            rd_bank        <= 1'b1;
            frame_done     <= 1'b0;
            err_short_line <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            state          <= state_nxt;
            wr_bank        <= wr_bank_nxt;
            x              <= x_nxt;
            y              <= y_nxt;
            addr           <= addr_nxt;
            line_base      <= base_nxt;
            pack           <= pack_nxt;
            latch_cnt      <= lcnt_nxt;
            fb_addr        <= faddr_nxt;
            fb_wdata       <= wdata_nxt;
            fb_we          <= we_nxt;
            rd_bank        <= rd_nxt;
            frame_done     <= done_nxt;
            err_short_line <= es_nxt;
            err_overflow   <= eo_nxt;
        end
    end

endmodule

// File: tb/tb_gb_frame_capture.sv
// Testbench for gb_frame_capture: drives LCD sequences and scoreboards every framebuffer write.
// Latency: n/a.
// Backpressure: n/a.
module tb_gb_frame_capture;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  pixel_data = 2'd0;
    logic        pixel_clock = 1'b0;
    logic        pixel_latch = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [13:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_we;
    logic        rd_bank;
    logic        frame_done;
    logic        err_short_line;
    logic        err_overflow;

    always #5 clock = ~clock;

    gb_frame_capture dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pixel_data     (pixel_data),
        .pixel_clock    (pixel_clock),
        .pixel_latch    (pixel_latch),
        .hsync          (hsync),
        .vsync          (vsync),
        .fb_addr        (fb_addr),
        .fb_wdata       (fb_wdata),
        .fb_we          (fb_we),
        .rd_bank        (rd_bank),
        .frame_done     (frame_done),
        .err_short_line (err_short_line),
        .err_overflow   (err_overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [13:0] last_addr = 14'd0;
    logic [21:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every fb_we must match the oldest expected {addr, data}.
    always @(negedge clock) begin
        if (frame_done) done_cnt++;
        if (fb_we) begin
            wr_cnt++;
            last_addr = fb_addr;
            check("we_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("wr_addr_data", {fb_addr, fb_wdata}, sb.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_vs();
        vsync = 1'b1; tick(1); vsync = 1'b0; tick(1);
    endtask

    task automatic pulse_hs();
        hsync = 1'b1; tick(1); hsync = 1'b0; tick(1);
    endtask

    task automatic pulse_latch();
        pixel_latch = 1'b1; tick(1); pixel_latch = 1'b0; tick(1);
    endtask

    task automatic send_pix(input logic [1:0] p);
        pixel_data = p; pixel_clock = 1'b1; tick(1); pixel_clock = 1'b0; tick(1);
    endtask

    // One line of n pixels (shade<0 -> random) ending with a latch pulse; expected
    // writes are queued before the pixel that triggers them. A partial tail byte
    // is queued for the flush the following hsync/vsync produces.
    task automatic send_line(input int n, input int base, input int shade);
        logic [7:0] acc;
        logic [1:0] p;
        acc = 8'd0;
        for (int i = 0; i < n; i++) begin
            p = (shade < 0) ? 2'($urandom_range(0, 3)) : 2'(shade);
            if (i < 160) begin
                acc[7 - 2*(i%4) -: 2] = p;
                if (i % 4 == 3) begin
                    sb.push_back({14'(base + i/4), acc});
                    acc = 8'd0;
                end
            end
            send_pix(p);
        end
        if (n < 160 && n % 4 != 0) sb.push_back({14'(base + n/4), acc});
        pulse_latch();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(fb_we), 32'd0);
        check({tag, "_addr"},  32'(fb_addr), 32'd0);
        check({tag, "_wdata"}, 32'(fb_wdata), 32'd0);
        check({tag, "_rdbank"}, 32'(rd_bank), 32'd1);
        check({tag, "_done"},  32'(frame_done), 32'd0);
        check({tag, "_eshort"}, 32'(err_short_line), 32'd0);
        check({tag, "_eovf"},  32'(err_overflow), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;
        int lat;
        bit found;

        #2 reset_n = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick(5);

        // Pixels before any vsync are ignored.
        for (int i = 0; i < 10; i++) send_pix(2'($urandom_range(0, 3)));
        tick(8);
        check("prevs_writes", 32'(wr_cnt), 32'd0);
        check("prevs_rdbank", 32'(rd_bank), 32'd1);
        check("prevs_eshort", 32'(err_short_line), 32'd0);
        check("prevs_eovf", 32'(err_overflow), 32'd0);

        // First byte: 3,2,1,0 -> E4 at address 0; latency measured from the pin.
        pulse_vs();
        pulse_hs();
        send_pix(2'd3); send_pix(2'd2); send_pix(2'd1);
        sb.push_back({14'd0, 8'hE4});
        pixel_data = 2'd0;
        pixel_clock = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 8 && !found; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (fb_we) begin
                found = 1'b1;
                lat = k;
            end
        end
        pixel_clock = 1'b0;
        tick(1);
        check("first_we_latency", 32'(lat), 32'd4);
        tick(6);
        check("first_write_count", 32'(wr_cnt), 32'd1);

        // Full frame into bank 0.
        pulse_vs();
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int l = 0; l < 144; l++) begin
            pulse_hs();
            send_line(160, 40*l, -1);
        end
        pulse_vs();
        tick(8);
        check("frame_writes", 32'(wr_cnt - w0), 32'd5760);
        check("frame_last_addr", 32'(last_addr), 32'd5759);
        check("frame_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("frame_rdbank", 32'(rd_bank), 32'd0);
        check("frame_eshort", 32'(err_short_line), 32'd0);
        check("frame_eovf", 32'(err_overflow), 32'd0);

        // Short line of six shade-3 pixels in bank 1: FF @5760, F0 @5761.
        pulse_hs();
        send_line(6, 5760, 3);
        pulse_hs();
        tick(8);
        check("short_eshort", 32'(err_short_line), 32'd1);
        check("short_eovf", 32'(err_overflow), 32'd0);
        check("short_last_addr", 32'(last_addr), 32'd5761);
        send_line(160, 5800, -1);

        // Overlong line: only 40 bytes written, overflow flagged.
        pulse_hs();
        w0 = wr_cnt;
        send_line(165, 5840, -1);
        tick(8);
        check("long_writes", 32'(wr_cnt - w0), 32'd40);
        check("long_last_addr", 32'(last_addr), 32'd5879);
        check("long_eovf", 32'(err_overflow), 32'd1);
        pulse_hs();

        // Reset while the 4th pixel of a group is still in the synchronizer.
        send_pix(2'd1); send_pix(2'd2); send_pix(2'd3);
        pixel_data = 2'd2;
        pixel_clock = 1'b1;
        tick(2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        pixel_clock = 1'b0;
        w0 = wr_cnt;
        tick(5);
        reset_n = 1'b1;
        tick(5);
        for (int i = 0; i < 8; i++) send_pix(2'($urandom_range(0, 3)));
        pulse_hs();
        for (int i = 0; i < 4; i++) send_pix(2'($urandom_range(0, 3)));
        tick(8);
        check("postrst_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("postrst_rdbank", 32'(rd_bank), 32'd1);

        d0 = done_cnt;
        pulse_vs();
        pulse_hs();
        send_line(160, 0, -1);
        pulse_hs();
        pulse_vs();
        tick(8);
        check("rst_f1_rdbank", 32'(rd_bank), 32'd0);
        check("rst_f1_done", 32'(done_cnt - d0), 32'd1);
        pulse_hs();
        send_line(160, 5760, -1);
        pulse_hs();
        pulse_vs();
        tick(8);
        check("rst_f2_rdbank", 32'(rd_bank), 32'd1);
        check("rst_f2_done", 32'(done_cnt - d0), 32'd2);
        check("rst_f2_eshort", 32'(err_short_line), 32'd0);
        check("rst_f2_eovf", 32'(err_overflow), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
